pipe_sequencer: RTL and testbench
=================================

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL provide parameter MUL_LAT, default 4: total EX-stage occupancy in cycles of a multiply (legal range 3..255).
REQ-002 SHALL provide parameter DIV_LAT, default 34: total EX-stage occupancy in cycles of a divide (legal range 3..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port hz_stall, input, 1 bit: stall request from the hazard detection unit, valid in the current cycle.
REQ-006 SHALL have port br_taken, input, 1 bit: branch in ID resolved taken.
REQ-007 SHALL have port jump, input, 1 bit: jump in ID.
REQ-008 SHALL have port mdu_start, input, 1 bit: a mul/div occupies EX.
REQ-009 SHALL have port mdu_div, input, 1 bit: 1 = divide, 0 = multiply; sampled with mdu_start.
REQ-010 SHALL have port cnt_clr, input, 1 bit: synchronous clear of the performance counters.
REQ-011 SHALL have outputs pc_en, ifid_en, ifid_flush, idex_flush, ex_hold and mdu_done, 1 bit each, as the pipeline stage controls.
REQ-012 SHALL have port state, output, 2 bits: 0 = RUN, 1 = MDU_BUSY, 2 = MDU_DONE.
REQ-013 SHALL have ports stall_cnt and flush_cnt, output, 16 bits each: performance counters.

Function
REQ-014 SHALL decode the stage controls combinationally from the registered state and the current inputs; only state, the latency counter and the performance counters are registered.
REQ-015 SHALL, in RUN, apply this priority:
- hz_stall=1: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
- else br_taken|jump: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0.
- else: pc_en=1, ifid_en=1, both flushes 0.
REQ-016 SHALL hold ex_hold=0 and mdu_done=0 in RUN.
REQ-017 SHALL, in RUN with mdu_start=1, go to MDU_BUSY and load the 8-bit latency counter with (mdu_div ? DIV_LAT : MUL_LAT) - 3; the REQ-015 outputs still apply in that cycle.
REQ-018 SHALL, in MDU_BUSY, drive pc_en=0, ifid_en=0, ex_hold=1, ifid_flush=0 and idex_flush=0, and ignore hz_stall, br_taken and jump.
REQ-019 SHALL, in MDU_BUSY, decrement the latency counter each cycle and go to MDU_DONE in the cycle after the counter reads 0, so the EX stage is occupied exactly LAT cycles (start cycle + LAT-2 busy cycles + done cycle).
REQ-020 SHALL, in MDU_DONE, drive mdu_done=1 and ex_hold=0, apply the REQ-015 decode, and return to RUN unconditionally.
REQ-021 SHALL ignore mdu_start in MDU_BUSY and MDU_DONE, because it is still asserted by the completing instruction.
REQ-022 SHALL, for back-to-back mul/div, take the second mdu_start in the RUN cycle that follows MDU_DONE.

Reset
REQ-023 SHALL, while reset=1 and independent of clk, force state=RUN, latency counter=0, stall_cnt=0 and flush_cnt=0.
REQ-024 SHALL, while reset=1, drive pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, ex_hold=0 and mdu_done=0.
REQ-025 SHALL abort an operation in progress if reset is asserted during MDU_BUSY or MDU_DONE; no mdu_done pulse is produced afterwards.

Configuration
REQ-026 SHALL, with macro PIPE_PERF_CNT_EN defined, count as follows:
- stall_cnt increments in every cycle with pc_en=0.
- flush_cnt increments in every cycle with ifid_flush|idex_flush.
- Both counters saturate at 16'hFFFF.
- cnt_clr=1 zeroes both counters at the next edge and has priority over increment.
REQ-027 SHALL, without PIPE_PERF_CNT_EN, tie stall_cnt and flush_cnt to 0, ignore cnt_clr, and contain no counter registers.

Verification
REQ-028 SHALL cover: reset released, hz_stall=1 for 1 cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
REQ-029 SHALL cover: hz_stall=1 and br_taken=1 in the same RUN cycle -> stall outputs only, ifid_flush=0.
REQ-030 SHALL cover: mdu_start=1, mdu_div=0, MUL_LAT=4 -> 2 cycles in MDU_BUSY with ex_hold=1, then 1 cycle in MDU_DONE with mdu_done=1, then RUN; mdu_start held high throughout causes no retrigger.
REQ-031 SHALL cover: divide with DIV_LAT=34, reset asserted in the 10th busy cycle -> state=RUN immediately, ex_hold=0, and no mdu_done pulse.
REQ-032 SHALL cover, with PIPE_PERF_CNT_EN defined:
- Hold hz_stall=1 for 70000 cycles -> stall_cnt=16'hFFFF.
- Then pulse cnt_clr -> stall_cnt=0 at the next edge.
REQ-033 SHALL cover: jump=1 for one RUN cycle -> ifid_flush=1 and pc_en=1 that cycle; with PIPE_PERF_CNT_EN defined, flush_cnt increments by exactly 1.

Source files
------------

// File: rtl/pipe_sequencer.sv
// Pipeline stall/flush sequencer with a multi-cycle mul/div EX hold.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_sequencer #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hz_stall,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        mdu_start,
    input  logic        mdu_div,
    input  logic        cnt_clr,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        ex_hold,
    output logic        mdu_done,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Start and done cycles are outside the busy count, hence the -3.
    localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 3);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 3);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_lat;
    logic [7:0] w_lat_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_lat   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        ex_hold     = 1'b0;
        mdu_done    = 1'b0;
        unique case (r_state)
            S_BUSY: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                ex_hold = 1'b1;
                if (r_lat == 8'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_lat_nxt = r_lat - 8'd1;
                end
            end
            default: begin
                if (hz_stall) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (br_taken | jump) begin
                    ifid_flush = 1'b1;
                end
                if (r_state == S_DONE) begin
                    mdu_done    = 1'b1;
                    w_state_nxt = S_RUN;
                end else if (mdu_start) begin
                    w_state_nxt = S_BUSY;
                    w_lat_nxt   = mdu_div ? DIV_LOAD : MUL_LOAD;
                end
            end
        endcase
        // Reset parks the pipe: nothing fetched, both stage registers flushed.
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            ex_hold    = 1'b0;
            mdu_done   = 1'b0;
        end
    end

    assign state = r_state;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else if (cnt_clr) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!pc_en && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if ((ifid_flush | idex_flush) && r_flush_cnt != 16'hFFFF) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    logic w_unused;
    assign w_unused  = cnt_clr;
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer against an occupancy-count model.
module tb_pipe_sequencer;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        hz_stall;
    logic        br_taken;
    logic        jump;
    logic        mdu_start;
    logic        mdu_div;
    logic        cnt_clr;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        ex_hold;
    logic        mdu_done;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    always #5 clk = ~clk;

    pipe_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .hz_stall(hz_stall),
        .br_taken(br_taken), .jump(jump), .mdu_start(mdu_start),
        .mdu_div(mdu_div), .cnt_clr(cnt_clr), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .ex_hold(ex_hold),
        .mdu_done(mdu_done), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Model: remaining busy cycles, a pending done cycle, event counts.
    int m_busy;
    bit m_done;
    int m_stall;
    int m_flush;

    logic [5:0] w_ctrl;
    assign w_ctrl = {pc_en, ifid_en, ifid_flush, idex_flush,
                     ex_hold, mdu_done};

    function automatic logic [5:0] exp_ctrl();
        if (reset) return 6'b001100;
        if (m_busy > 0) return 6'b000010;
        if (hz_stall) return {5'b00010, m_done};
        if (br_taken || jump) return {5'b11100, m_done};
        return {5'b11000, m_done};
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_busy > 0) return 2'd1;
        if (m_done) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [15:0] exp_stall();
`ifdef PIPE_PERF_CNT_EN
        return 16'(m_stall);
`else
        return 16'h0;
`endif
    endfunction

    function automatic logic [15:0] exp_flush();
`ifdef PIPE_PERF_CNT_EN
        return 16'(m_flush);
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_done = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_step();
        logic [5:0] c;
        c = exp_ctrl();
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!c[5] && m_stall < 65535) m_stall++;
            if ((c[3] || c[2]) && m_flush < 65535) m_flush++;
        end
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_done = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (mdu_start) begin
            m_busy = (mdu_div ? DIV_LAT : MUL_LAT) - 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        hz_stall = 0; br_taken = 0; jump = 0;
        mdu_start = 0; mdu_div = 0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        model_reset();
        #3;
        n_cmp++;
        if (w_ctrl !== 6'b001100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 001100", w_ctrl);
        end
        n_cmp++;
        if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_regs: st=%0d sc=%0d fc=%0d want 0",
                     state, stall_cnt, flush_cnt);
        end
        mdu_start = 1;
        tick();
        tick();
        n_cmp++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold_state: got %0d want 0", state);
        end
        mdu_start = 0;
        reset = 0;
        #3;
        n_cmp++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 110000", w_ctrl);
        end
        tick();
    endtask

    task automatic test_stall();
        hz_stall = 1;
        #3;
        n_cmp++;
        if (w_ctrl !== 6'b000100 || w_ctrl !== exp_ctrl()) begin
            n_fail++;
            $display("FAIL stall_cycle: got %b want 000100", w_ctrl);
        end
        tick();
        hz_stall = 0;
        #3;
        n_cmp++;
        if (w_ctrl !== 6'b110000) begin
            n_fail++;
            $display("FAIL stall_after: got %b want 110000", w_ctrl);
        end
        tick();
    endtask

    task automatic test_stall_branch();
        hz_stall = 1;
        br_taken = 1;
        #3;
        n_cmp++;
        if (w_ctrl !== 6'b000100) begin
            n_fail++;
            $display("FAIL stall_branch: got %b want 000100", w_ctrl);
        end
        tick();
        hz_stall = 0;
        #3;
        n_cmp++;
        if (w_ctrl !== 6'b111000) begin
            n_fail++;
            $display("FAIL branch_flush: got %b want 111000", w_ctrl);
        end
        tick();
        br_taken = 0;
    endtask

    task automatic test_mul();
        logic [1:0] st_exp [5];
        logic [5:0] c_exp [5];
        st_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        c_exp = '{6'b110000, 6'b000010, 6'b000010, 6'b110001, 6'b110000};
        mdu_start = 1;
        mdu_div = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) mdu_start = 0;
            #3;
            n_cmp++;
            if (state !== st_exp[i] || w_ctrl !== c_exp[i]) begin
                n_fail++;
                $display("FAIL mul_seq[%0d]: st=%0d ctrl=%b want st=%0d ctrl=%b",
                         i, state, w_ctrl, st_exp[i], c_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        mdu_start = 1;
        mdu_div = 0;
        for (int i = 0; i < 2 * MUL_LAT + 1; i++) begin
            if (i == 2 * MUL_LAT) mdu_start = 0;
            #3;
            n_cmp++;
            if (state !== exp_state() || w_ctrl !== exp_ctrl()) begin
                n_fail++;
                $display("FAIL b2b[%0d]: st=%0d ctrl=%b want st=%0d ctrl=%b",
                         i, state, w_ctrl, exp_state(), exp_ctrl());
            end
            tick();
        end
        #3;
        n_cmp++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_end: st=%0d want 0", state);
        end
        tick();
    endtask

    task automatic test_div_reset();
        int bad;
        mdu_start = 1;
        mdu_div = 1;
        tick();
        for (int i = 1; i < 10; i++) tick();
        #1;
        reset = 1;
        mdu_start = 0;
        model_reset();
        #1;
        n_cmp++;
        if (state !== 2'd0 || ex_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL div_abort: st=%0d ex_hold=%b want 0/0",
                     state, ex_hold);
        end
        tick();
        reset = 0;
        mdu_div = 0;
        bad = 0;
        for (int i = 0; i < DIV_LAT + 6; i++) begin
            #3;
            if (mdu_done !== 1'b0 || state !== 2'd0) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL div_no_done: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_jump();
        int f0;
        f0 = m_flush;
        jump = 1;
        #3;
        n_cmp++;
        if (ifid_flush !== 1'b1 || pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_ctrl: flush=%b pc_en=%b want 1/1",
                     ifid_flush, pc_en);
        end
        tick();
        jump = 0;
        #3;
        n_cmp++;
`ifdef PIPE_PERF_CNT_EN
        if (flush_cnt !== 16'(f0 + 1)) begin
            n_fail++;
            $display("FAIL jump_cnt: got %0d want %0d", flush_cnt, f0 + 1);
        end
`else
        if (flush_cnt !== 16'd0 || f0 < 0) begin
            n_fail++;
            $display("FAIL jump_cnt: got %0d want 0", flush_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            hz_stall  = ($urandom_range(0, 3) == 0);
            br_taken  = ($urandom_range(0, 5) == 0);
            jump      = ($urandom_range(0, 7) == 0);
            mdu_start = ($urandom_range(0, 4) == 0);
            mdu_div   = ($urandom_range(0, 5) == 0);
            cnt_clr   = ($urandom_range(0, 40) == 0);
            #3;
            n_cmp++;
            if (w_ctrl !== exp_ctrl() || state !== exp_state() ||
                stall_cnt !== exp_stall() || flush_cnt !== exp_flush()) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand[%0d]: ctrl=%b st=%0d sc=%0d fc=%0d want %b %0d %0d %0d",
                             i, w_ctrl, state, stall_cnt, flush_cnt,
                             exp_ctrl(), exp_state(), exp_stall(), exp_flush());
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < DIV_LAT + 2; i++) tick();
    endtask

    task automatic test_perf_sat();
        hz_stall = 1;
        for (int i = 0; i < 70000; i++) tick();
        #3;
        n_cmp++;
`ifdef PIPE_PERF_CNT_EN
        if (stall_cnt !== 16'hFFFF || stall_cnt !== exp_stall()) begin
            n_fail++;
            $display("FAIL stall_sat: got %h want FFFF", stall_cnt);
        end
`else
        if (stall_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL stall_tied: got %h want 0", stall_cnt);
        end
`endif
        hz_stall = 0;
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        #3;
        n_cmp++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL cnt_clr: sc=%h fc=%h want 0/0",
                     stall_cnt, flush_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stall();
        test_stall_branch();
        test_mul();
        test_back_to_back();
        test_div_reset();
        test_jump();
        test_random();
`ifdef PIPE_PERF_CNT_EN
        test_perf_sat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
